// File: rtl/btn_debounce_clr.sv
// Push-button debouncer that turns each accepted press into a one-cycle
// active-low synchronous clear for the downstream counter stage. It also
// exports the debounced level and press/release strobes.
//
// state       | meaning
// ------------+--------------------------------------------------------
// RELEASED    | debounced level is 0, waiting for a synced 1
// CHK_PRESS   | synced input is 1, counting stable samples before accept
// PRESSED     | debounced level is 1, waiting for a synced 0
// CHK_RELEASE | synced input is 0, counting stable samples before accept
module btn_debounce_clr #(
  parameter int CNT_BW        = 16,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic nclr_o
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  // Terminal count; STABLE_CYCLES == 2**CNT_BW maps onto the all-ones value.
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(STABLE_CYCLES - 1);

  logic              sync1_q;
  logic              sync2_q;
  state_t            state_q;
  state_t            state_d;
  logic [CNT_BW-1:0] cnt_q;
  logic [CNT_BW-1:0] cnt_d;
  logic              level_d;
  logic              press_d;
  logic              release_d;
  logic              nclr_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= RELEASED;
      cnt_q           <= '0;
      btn_level_o     <= 1'b0;
      press_pulse_o   <= 1'b0;
      release_pulse_o <= 1'b0;
      nclr_o          <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_level_o     <= level_d;
      press_pulse_o   <= press_d;
      release_pulse_o <= release_d;
      nclr_o          <= nclr_d;
    end
  end

  // Next-state logic; strobes default inactive so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level_o;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = CHK_PRESS;
          cnt_d   = '0;
        end
      end

      CHK_PRESS: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      PRESSED: begin
        if (!sync2_q) begin
          state_d = CHK_RELEASE;
          cnt_d   = '0;
        end
      end

      CHK_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    nclr_d = ~press_d;
  end

endmodule
